tt_um_dalinem_sar_readout: RTL and testbench

Digital readout controller for the team's differential amplifier tile, used with the amplifier running open-loop as a comparator. The block drives an 8-bit code onto `uo_out` into an external R-2R ladder that feeds the amplifier's inverting input. It reads the amplifier output back on `ui_in[0]` and runs an 8-step successive-approximation search, producing the code at which the amplifier output flips. It occupies its own Tiny Tapeout tile and is the digital receiving end of the amplifier's analog output.

---
 rtl/tt_um_dalinem_sar_readout.sv | 223 ++++++++++++++++++++++
 tb/tb_tt_um_dalinem_sar_readout.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_dalinem_sar_readout.sv
// -----------------------------------------------------------------------------
// tt_um_dalinem_sar_readout
//
// Successive-approximation readout for the differential amplifier tile. The
// amplifier runs open-loop as a comparator. This block drives an 8-bit trial
// code into an external R-2R ladder, reads the comparator level back, and
// binary-searches for the code at which the comparator output flips.
//
// Optional feature: define SAR_AVG_EN to make one start run four back-to-back
// conversions and report the truncated mean of the four codes.
//
// Ports
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   ena      tile enable; low aborts any conversion (result/done are kept)
//   ui_in    [0] comparator level (asynchronous)
//            [1] start (rising edge)
//            [4:2] settle select S, N = (S+1)*SETTLE_UNIT clocks per trial
//            [6:5] unused
//            [7] uio_out view select: 0 = result, 1 = status
//   uo_out   DAC trial code, holds the final code after a conversion
//   uio_in   unused
//   uio_out  result, or {busy, done, avg_idx[1:0], 4'b0} when ui_in[7]=1
//   uio_oe   constant 8'hFF (all bidirectional pins drive)
// -----------------------------------------------------------------------------
module tt_um_dalinem_sar_readout #(
  parameter int SETTLE_UNIT = 4  // 1..31
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DECIDE = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [7:0] UNIT = 8'(SETTLE_UNIT);

  // Synchronisers for the two asynchronous pin inputs.
  logic cmp_s1, cmp_sync;
  logic start_s1, start_sync, start_sync_d;
  logic start_pulse;

  state_t     state_q, state_d;
  logic [7:0] code_q, code_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] n_q, n_d;       // settle length captured at accept
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] result_q, result_d;
  logic [7:0] n_calc;

`ifdef SAR_AVG_EN
  logic [1:0] avg_idx_q, avg_idx_d;
  logic [9:0] acc_q, acc_d;
  logic [9:0] acc_sum;
  assign acc_sum = acc_q + {2'b00, code_q};
`endif

  // Pins that carry no function in this tile.
  logic unused_ok;
  assign unused_ok = &{1'b0, uio_in, ui_in[6:5]};

  assign start_pulse = start_sync & ~start_sync_d;
  // Max (7+1)*31 = 248, so the 8-bit product never wraps.
  assign n_calc      = ({5'd0, ui_in[4:2]} + 8'd1) * UNIT;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_s1       <= 1'b0;
      cmp_sync     <= 1'b0;
      start_s1     <= 1'b0;
      start_sync   <= 1'b0;
      start_sync_d <= 1'b0;
    end else begin
      cmp_s1       <= ui_in[0];
      cmp_sync     <= cmp_s1;
      start_s1     <= ui_in[1];
      start_sync   <= start_s1;
      start_sync_d <= start_sync;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      code_q    <= 8'h00;
      idx_q     <= 3'd0;
      cnt_q     <= 8'd0;
      n_q       <= 8'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= 8'h00;
`ifdef SAR_AVG_EN
      avg_idx_q <= 2'd0;
      acc_q     <= 10'd0;
`endif
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      n_q       <= n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
`ifdef SAR_AVG_EN
      avg_idx_q <= avg_idx_d;
      acc_q     <= acc_d;
`endif
    end
  end

  always_comb begin
    // NOTE: every signal gets a hold-value default before any branch, so no
    // path through the case leaves a variable unassigned and no latch forms.
    state_d   = state_q;
    code_d    = code_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    n_d       = n_q;
    busy_d    = busy_q;
    done_d    = done_q;
    result_d  = result_q;
`ifdef SAR_AVG_EN
    avg_idx_d = avg_idx_q;
    acc_d     = acc_q;
`endif

    if (!ena) begin
      // Abort wins over everything; the last result and done flag survive.
      state_d = IDLE;
      busy_d  = 1'b0;
      code_d  = 8'h00;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_pulse) begin
            code_d    = 8'h80;
            idx_d     = 3'd7;
            cnt_d     = n_calc - 8'd1;
            n_d       = n_calc;
            busy_d    = 1'b1;
            done_d    = 1'b0;
`ifdef SAR_AVG_EN
            avg_idx_d = 2'd0;
            acc_d     = 10'd0;
`endif
            state_d   = SETTLE;
          end
        end

        SETTLE: begin
          if (cnt_q == 8'd0) state_d = DECIDE;
          else               cnt_d   = cnt_q - 8'd1;
        end

        DECIDE: begin
          // Comparator low means the DAC is above vin+: drop the trial bit.
          if (!cmp_sync) code_d[idx_q] = 1'b0;
          if (idx_q == 3'd0) begin
            state_d = FINISH;
          end else begin
            code_d[idx_q - 3'd1] = 1'b1;
            idx_d   = idx_q - 3'd1;
            cnt_d   = n_q - 8'd1;
            state_d = SETTLE;
          end
        end

        FINISH: begin
`ifdef SAR_AVG_EN
          acc_d = acc_sum;
          if (avg_idx_q == 2'd3) begin
            result_d = acc_sum[9:2];
            done_d   = 1'b1;
            busy_d   = 1'b0;
            state_d  = IDLE;
          end else begin
            // Next pass starts straight away, like a fresh accept.
            avg_idx_d = avg_idx_q + 2'd1;
            code_d    = 8'h80;
            idx_d     = 3'd7;
            cnt_d     = n_q - 8'd1;
            state_d   = SETTLE;
          end
`else
          result_d = code_q;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
`endif
        end

        default: state_d = IDLE;
      endcase
    end
  end

  logic [7:0] status;
`ifdef SAR_AVG_EN
  assign status = {busy_q, done_q, avg_idx_q, 4'b0000};
`else
  assign status = {busy_q, done_q, 2'b00, 4'b0000};
`endif

  assign uo_out  = code_q;
  assign uio_out = ui_in[7] ? status : result_q;
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_dalinem_sar_readout.sv
// -----------------------------------------------------------------------------
// Testbench for tt_um_dalinem_sar_readout (SETTLE_UNIT = 4).
// The comparator model is cmp = (uo_out <= thr), delayed two clocks to the pin.
// Status view (ui_in[7]=1) is the default so busy/done can be watched; the
// result view is selected briefly whenever the result is read.
// -----------------------------------------------------------------------------
module tb_tt_um_dalinem_sar_readout;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       start;
  logic [2:0] sel;
  logic       view;
  logic       cmp_pin;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int  thr;
  bit  cmp_zero;
  logic d1, d2;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] hist [0:2047];

  assign ui_in  = {view, 2'b00, sel, start, cmp_pin};
  assign uio_in = 8'h00;
  assign cmp_pin = d2;

  tt_um_dalinem_sar_readout #(.SETTLE_UNIT(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Comparator model with two clocks of pin delay.
  always @(posedge clk) begin
    d1 <= cmp_zero ? 1'b0 : (int'(uo_out) <= thr);
    d2 <= d1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int conv_len(input int n);
`ifdef SAR_AVG_EN
    return 4 * (8 * (n + 1) + 1);
`else
    return 8 * (n + 1) + 1;
`endif
  endfunction

  task automatic read_result(output logic [7:0] r);
    view = 1'b0;
    #1;
    r = uio_out;
    view = 1'b1;
    #1;
  endtask

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic start_conv(input string tag);
    bit ok = 0;
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (uio_out[7]) begin
        ok = 1;
        break;
      end
    end
    start = 1'b0;
    check({tag, "_accept"}, 32'(ok), 32'd1);
  endtask

  task automatic run_conv(input string tag, input logic [2:0] s, input int t,
                          input logic [7:0] exp_res, input logic [63:0] trials);
    int n = (int'(s) + 1) * 4;
    int cyc = 0;
    logic [7:0] r;
    sel = s;
    thr = t;
    start_conv(tag);
    hist[0] = uo_out;
    while (!uio_out[6] && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      hist[cyc] = uo_out;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(conv_len(n)));
    for (int j = 0; j < 8; j++) begin
      check($sformatf("%s_trial%0d", tag, j), 32'(hist[j * (n + 1)]),     32'(trials[63 - 8 * j -: 8]));
      check($sformatf("%s_hold%0d", tag, j),  32'(hist[j * (n + 1) + n]), 32'(trials[63 - 8 * j -: 8]));
    end
    check({tag, "_final_code"}, 32'(uo_out), 32'(exp_res));
    read_result(r);
    check({tag, "_result"}, 32'(r), 32'(exp_res));
  endtask

  initial begin
    logic [7:0] r;
    logic [7:0] done_status;
    int  cyc;
    int  rises;
    bit  prev_busy;
    bit  gap;

`ifdef SAR_AVG_EN
    done_status = 8'h70;
`else
    done_status = 8'h40;
`endif

    rst_n = 1'b1;
    ena = 1'b1;
    start = 1'b0;
    sel = 3'd0;
    view = 1'b0;
    thr = 'h5A;
    cmp_zero = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("reset_uo_out", 32'(uo_out), 32'h00);
    check("reset_result", 32'(uio_out), 32'h00);
    check("reset_uio_oe", 32'(uio_oe), 32'hFF);
    view = 1'b1;
    #1;
    check("reset_status", 32'(uio_out), 32'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single conversion, S=0 (N=4).
    run_conv("single", 3'd0, 'h5A, 8'h5A, 64'h80_40_60_50_58_5C_5A_5B);
    check("status_done", 32'(uio_out), 32'(done_status));

    // Rails.
    run_conv("rail_hi", 3'd0, 'hFF, 8'hFF, 64'h80_C0_E0_F0_F8_FC_FE_FF);
    cmp_zero = 1'b1;
    run_conv("rail_lo", 3'd0, 'h5A, 8'h00, 64'h80_40_20_10_08_04_02_01);
    cmp_zero = 1'b0;

    // Start held high for 100 clocks: exactly one conversion.
    thr = 'h5A;
    sel = 3'd0;
    rises = 0;
    prev_busy = uio_out[7];
    start = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (uio_out[7] && !prev_busy) rises++;
      prev_busy = uio_out[7];
    end
    start = 1'b0;
    cyc = 0;
    while (!uio_out[6] && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (uio_out[7] && !prev_busy) rises++;
      prev_busy = uio_out[7];
    end
    repeat (10) begin
      @(negedge clk);
      if (uio_out[7] && !prev_busy) rises++;
      prev_busy = uio_out[7];
    end
    check("held_start_conversions", 32'(rises), 32'd1);
    read_result(r);
    check("held_start_result", 32'(r), 32'h5A);

    // Second start while busy is ignored; busy holds until done.
    start_conv("busy_ign");
    cyc = 0;
    gap = 0;
    while (!uio_out[6] && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 5)  check("status_busy", 32'(uio_out), 32'h80);
      if (cyc == 10) start = 1'b1;
      if (cyc == 15) start = 1'b0;
      if (!uio_out[7] && !uio_out[6]) gap = 1;
    end
    check("busy_ign_latency", 32'(cyc), 32'(conv_len(4)));
    check("busy_ign_no_gap", 32'(gap), 32'd0);
    repeat (10) @(negedge clk);
    check("busy_ign_no_requeue", 32'(uio_out[7:6]), 32'b01);
    read_result(r);
    check("busy_ign_result", 32'(r), 32'h5A);

    // Abort: ena low sampled at the 3rd DECIDE edge (accept + 15).
    start_conv("abort");
    repeat (14) @(negedge clk);
    ena = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(uio_out[7]), 32'd0);
    check("abort_done_kept", 32'(uio_out[6]), 32'd0);
    check("abort_uo_out", 32'(uo_out), 32'h00);
    read_result(r);
    check("abort_result_kept", 32'(r), 32'h5A);
    ena = 1'b1;
    @(negedge clk);

    // Asynchronous reset in the middle of a conversion.
    start_conv("rst_mid");
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_uo_out", 32'(uo_out), 32'h00);
    check("rst_mid_status", 32'(uio_out), 32'h00);
    check("rst_mid_uio_oe", 32'(uio_oe), 32'hFF);
    read_result(r);
    check("rst_mid_result", 32'(r), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // S=7: N=32, each trial held 33 clocks.
    run_conv("s7", 3'd7, 'h5A, 8'h5A, 64'h80_40_60_50_58_5C_5A_5B);

`ifdef SAR_AVG_EN
    // Four passes with thresholds 5A,5B,5A,5B: sum 0x16A, mean 0x5A.
    sel = 3'd0;
    thr = 'h5A;
    start_conv("avg");
    cyc = 0;
    while (!uio_out[6] && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 41)  thr = 'h5B;
      if (cyc == 82)  thr = 'h5A;
      if (cyc == 90)  check("avg_status_pass2", 32'(uio_out), 32'hA0);
      if (cyc == 123) thr = 'h5B;
    end
    check("avg_latency", 32'(cyc), 32'(4 * 41));
    check("avg_last_code", 32'(uo_out), 32'h5B);
    read_result(r);
    check("avg_result", 32'(r), 32'h5A);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
